// File: rtl/pq_cmd_pkg.sv
// pq_cmd_pkg: types shared by the priority-queue command driver and its benches.
package pq_cmd_pkg;

  typedef enum logic [1:0] {
    ENQUEUE = 2'd0,
    DEQUEUE = 2'd1,
    REPLACE = 2'd2,
    PEEK    = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam int OP_GAP_MAX = 15;

  // An op is refused when the queue flags seen at handshake make it impossible.
  function automatic logic op_rejected(op_t op, logic full, logic empty);
    logic rejected;
    rejected = 1'b0;
    case (op)
      ENQUEUE:          rejected = full;
      DEQUEUE, REPLACE: rejected = empty;
      default:          rejected = 1'b0;
    endcase
    return rejected;
  endfunction

endpackage

// File: rtl/pq_cmd_driver_if.sv
// pq_cmd_driver_if: command and response channels between a host and the
// priority-queue command driver. The host is the master, the driver the slave.
interface pq_cmd_driver_if #(
  parameter int DATA_WIDTH = 16
);

  logic                  i_cmd_valid;
  logic                  o_cmd_ready;
  logic [1:0]            i_cmd_op;
  logic [DATA_WIDTH-1:0] i_cmd_data;

  logic                  o_rsp_valid;
  logic                  i_rsp_ready;
  logic [1:0]            o_rsp_op;
  logic [DATA_WIDTH-1:0] o_rsp_data;
  logic                  o_rsp_err;

  modport master (
    output i_cmd_valid, i_cmd_op, i_cmd_data, i_rsp_ready,
    input  o_cmd_ready, o_rsp_valid, o_rsp_op, o_rsp_data, o_rsp_err
  );

  modport slave (
    input  i_cmd_valid, i_cmd_op, i_cmd_data, i_rsp_ready,
    output o_cmd_ready, o_rsp_valid, o_rsp_op, o_rsp_data, o_rsp_err
  );

endinterface

// File: rtl/pq_cmd_stats.sv
// pq_cmd_stats: pair of 32-bit saturating event counters for the command driver.
module pq_cmd_stats (
  input  logic        CLK,
  input  logic        RST,
  input  logic        inc_ops,
  input  logic        inc_errs,
  output logic [31:0] o_stat_ops,
  output logic [31:0] o_stat_errs
);

  // Count each event, sticking at all-ones instead of wrapping.
  always_ff @(posedge CLK) begin
    if (RST) begin
      o_stat_ops  <= '0;
      o_stat_errs <= '0;
    end else begin
      if (inc_ops && (o_stat_ops != '1)) begin
        o_stat_ops <= o_stat_ops + 32'd1;
      end
      if (inc_errs && (o_stat_errs != '1)) begin
        o_stat_errs <= o_stat_errs + 32'd1;
      end
    end
  end

endmodule

// File: rtl/pq_cmd_driver.sv
// pq_cmd_driver: turns abstract ENQUEUE/DEQUEUE/REPLACE/PEEK commands into
// single-cycle write/read strobes on the register-array priority queue and
// returns one response per command.
// Optional build macro PQ_CMD_DRIVER_STATS_EN adds o_stat_ops/o_stat_errs.
module pq_cmd_driver
  import pq_cmd_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int OP_GAP     = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  pq_cmd_driver_if.slave        bus,
  output logic                  o_q_wrt,
  output logic                  o_q_read,
  output logic [DATA_WIDTH-1:0] o_q_data,
  input  logic                  i_q_full,
  input  logic                  i_q_empty,
  input  logic [DATA_WIDTH-1:0] i_q_top
`ifdef PQ_CMD_DRIVER_STATS_EN
  ,
  output logic [31:0]           o_stat_ops,
  output logic [31:0]           o_stat_errs
`endif
);

  localparam logic [3:0] GAP_LAST = 4'(OP_GAP - 1);

  state_t                state;
  state_t                state_nxt;
  op_t                   op_q;
  op_t                   cmd_op;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  rsp_err_q;
  logic [3:0]            gap_cnt;
  logic                  gap_done;
  logic                  ready_en;
  logic                  cmd_ready;
  logic                  accept;
  logic                  cmd_rejected;
  logic                  q_wrt;
  logic                  q_read;
  logic                  rsp_valid;

  assign cmd_op       = op_t'(bus.i_cmd_op);
  assign cmd_rejected = op_rejected(cmd_op, i_q_full, i_q_empty);
  assign gap_done     = (gap_cnt == GAP_LAST);

  // ready_en keeps o_cmd_ready low in the cycle right after a reset edge.
  assign cmd_ready = (state == IDLE) && ready_en;
  assign accept    = bus.i_cmd_valid && cmd_ready;

  // State register; reset drops any in-flight op or pending response.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      ready_en <= 1'b0;
    end else begin
      state    <= state_nxt;
      ready_en <= 1'b1;
    end
  end

  // Next-state decode and per-state strobes; strobes live only in ISSUE.
  always_comb begin
    state_nxt = state;
    q_wrt     = 1'b0;
    q_read    = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_rejected || (cmd_op == PEEK)) begin
            state_nxt = RESP;
          end else begin
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        q_wrt     = (op_q == ENQUEUE) || (op_q == REPLACE);
        q_read    = (op_q == DEQUEUE) || (op_q == REPLACE);
        state_nxt = WAIT;
      end
      WAIT: begin
        if (gap_done) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.i_rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch, settle counter and response payload capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q       <= ENQUEUE;
      data_q     <= '0;
      gap_cnt    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (state == WAIT) begin
        gap_cnt <= gap_cnt + 4'd1;
      end else begin
        gap_cnt <= '0;
      end

      if (accept) begin
        op_q      <= cmd_op;
        data_q    <= bus.i_cmd_data;
        rsp_err_q <= cmd_rejected;
        if (cmd_rejected) begin
          rsp_data_q <= (cmd_op == ENQUEUE) ? bus.i_cmd_data : '0;
        end else if ((cmd_op == PEEK) && i_q_empty) begin
          rsp_data_q <= '0;
        end else begin
          rsp_data_q <= i_q_top;
        end
      end else if ((state == WAIT) && gap_done && (op_q == ENQUEUE)) begin
        rsp_data_q <= i_q_top;
      end
    end
  end

  assign bus.o_cmd_ready = cmd_ready;
  assign bus.o_rsp_valid = rsp_valid;
  assign bus.o_rsp_op    = op_q;
  assign bus.o_rsp_data  = rsp_data_q;
  assign bus.o_rsp_err   = rsp_err_q;
  assign o_q_wrt         = q_wrt;
  assign o_q_read        = q_read;
  assign o_q_data        = data_q;

`ifdef PQ_CMD_DRIVER_STATS_EN
  pq_cmd_stats u_stats (
    .CLK         (CLK),
    .RST         (RST),
    .inc_ops     (accept),
    .inc_errs    (accept && cmd_rejected),
    .o_stat_ops  (o_stat_ops),
    .o_stat_errs (o_stat_errs)
  );
`endif

endmodule

// File: tb/tb_pq_cmd_driver.sv
// tb_pq_cmd_driver: random and directed commands against pq_cmd_driver, with a
// behavioural 8-entry priority queue as responder and a scoreboard of expected
// responses built from a command-level reference model.
module tb_pq_cmd_driver;
  import pq_cmd_pkg::*;

  localparam int DW    = 16;
  localparam int GAP   = 1;
  localparam int DEPTH = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          q_wrt;
  logic          q_read;
  logic [DW-1:0] q_data;
  logic          q_full  = 1'b0;
  logic          q_empty = 1'b1;
  logic [DW-1:0] q_top   = '0;
`ifdef PQ_CMD_DRIVER_STATS_EN
  logic [31:0]   stat_ops;
  logic [31:0]   stat_errs;
`endif

  pq_cmd_driver_if #(.DATA_WIDTH(DW)) bus ();

  pq_cmd_driver #(.DATA_WIDTH(DW), .OP_GAP(GAP)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .bus         (bus),
    .o_q_wrt     (q_wrt),
    .o_q_read    (q_read),
    .o_q_data    (q_data),
    .i_q_full    (q_full),
    .i_q_empty   (q_empty),
    .i_q_top     (q_top)
`ifdef PQ_CMD_DRIVER_STATS_EN
    ,
    .o_stat_ops  (stat_ops),
    .o_stat_errs (stat_errs)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    op_t           op;
    logic [DW-1:0] data;
    logic          err;
    logic          wrt;
    logic          rd;
    logic [DW-1:0] qdata;
    int            lat;
    int            acc_cyc;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] pq_mem[$];
  logic [DW-1:0] ref_q[$];
  int            cyc = 0;
  int            vectors = 0;
  int            miscompares = 0;
  int            seen_strobes = 0;
  int            rsp_rise_cyc = 0;
  logic          rsp_valid_prev = 1'b0;
  int            bench_ops = 0;
  int            bench_errs = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pqMaxIdx();
    int best = -1;
    foreach (pq_mem[i]) if (best < 0 || pq_mem[i] > pq_mem[best]) best = i;
    return best;
  endfunction

  function automatic int refMaxIdx();
    int best = -1;
    foreach (ref_q[i]) if (best < 0 || ref_q[i] > ref_q[best]) best = i;
    return best;
  endfunction

  // Responder: a max-priority queue reacting to the driver's strobes.
  always @(posedge CLK) begin : responder
    int idx;
    if (q_wrt && q_read) begin
      idx = pqMaxIdx();
      if (idx >= 0) pq_mem.delete(idx);
      pq_mem.push_back(q_data);
    end else if (q_wrt) begin
      if (pq_mem.size() < DEPTH) pq_mem.push_back(q_data);
    end else if (q_read) begin
      idx = pqMaxIdx();
      if (idx >= 0) pq_mem.delete(idx);
    end
    idx = pqMaxIdx();
    q_top   <= (idx >= 0) ? pq_mem[idx] : '0;
    q_full  <= (pq_mem.size() == DEPTH);
    q_empty <= (pq_mem.size() == 0);
  end

  // Command-level reference: what each op should return and which strobes it needs.
  function automatic exp_t modelCommand(input op_t op, input logic [DW-1:0] data, input int acc);
    exp_t e;
    int   idx;
    e.op = op; e.data = '0; e.err = 1'b0; e.wrt = 1'b0; e.rd = 1'b0;
    e.qdata = data; e.acc_cyc = acc; e.lat = 2 + GAP;
    idx = refMaxIdx();
    case (op)
      ENQUEUE: begin
        if (ref_q.size() == DEPTH) begin
          e.err = 1'b1; e.data = data; e.lat = 1;
        end else begin
          ref_q.push_back(data);
          e.wrt = 1'b1;
          e.data = ref_q[refMaxIdx()];
        end
      end
      DEQUEUE: begin
        if (idx < 0) begin
          e.err = 1'b1; e.lat = 1;
        end else begin
          e.data = ref_q[idx]; ref_q.delete(idx); e.rd = 1'b1;
        end
      end
      REPLACE: begin
        if (idx < 0) begin
          e.err = 1'b1; e.lat = 1;
        end else begin
          e.data = ref_q[idx]; ref_q.delete(idx); ref_q.push_back(data);
          e.wrt = 1'b1; e.rd = 1'b1;
        end
      end
      default: begin
        e.lat = 1;
        e.data = (idx < 0) ? '0 : ref_q[idx];
      end
    endcase
    return e;
  endfunction

  // Monitor: checks strobes against the pending command and pops responses.
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (RST) begin
      rsp_valid_prev = 1'b0;
    end else begin
      if (q_wrt || q_read) begin
        if (sb_q.size() == 0) begin
          checkOutput("strobe_without_cmd", 32'd1, 32'd0);
        end else begin
          checkOutput("strobe_cycle", cyc - sb_q[0].acc_cyc, 32'd1);
          checkOutput("strobe_wrt", q_wrt, sb_q[0].wrt);
          checkOutput("strobe_read", q_read, sb_q[0].rd);
          if (sb_q[0].wrt) checkOutput("strobe_data", q_data, sb_q[0].qdata);
        end
        seen_strobes++;
      end
      if (bus.o_rsp_valid && !rsp_valid_prev) rsp_rise_cyc = cyc;
      if (bus.o_rsp_valid && bus.i_rsp_ready) begin
        if (sb_q.size() == 0) begin
          checkOutput("rsp_without_cmd", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          checkOutput("rsp_op", bus.o_rsp_op, e.op);
          checkOutput("rsp_err", bus.o_rsp_err, e.err);
          checkOutput("rsp_data", bus.o_rsp_data, e.data);
          checkOutput("rsp_latency", rsp_rise_cyc - e.acc_cyc, e.lat);
          checkOutput("strobe_count", seen_strobes, (e.wrt || e.rd) ? 32'd1 : 32'd0);
        end
      end
      rsp_valid_prev = bus.o_rsp_valid && !bus.i_rsp_ready;
    end
  end

  task automatic syncEdge();
    @(posedge CLK);
    #1;
  endtask

  // Present one command, wait for the handshake and queue its expected response.
  task automatic applyStimulus(input op_t op, input logic [DW-1:0] data);
    int   n = 0;
    exp_t e;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_op    = op;
    bus.i_cmd_data  = data;
    @(negedge CLK);
    while (!bus.o_cmd_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (!bus.o_cmd_ready) begin
      checkOutput("cmd_accept_timeout", 32'd0, 32'd1);
    end else begin
      e = modelCommand(op, data, cyc);
      sb_q.push_back(e);
      seen_strobes = 0;
      bench_ops++;
      if (e.err) bench_errs++;
    end
    syncEdge();
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_op    = 2'($urandom_range(0, 3));
    bus.i_cmd_data  = 16'($urandom);
  endtask

  // Drain the scoreboard with a randomly stalling response consumer.
  task automatic waitResponse();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      syncEdge();
      bus.i_rsp_ready = ($urandom_range(0, 3) != 0);
      n++;
    end
    if (sb_q.size() != 0) begin
      checkOutput("rsp_timeout", sb_q.size(), 32'd0);
      sb_q.delete();
    end
    bus.i_rsp_ready = 1'b0;
  endtask

  task automatic checkResetZeros(input string tag);
    checkOutput({tag, "_cmd_ready"}, bus.o_cmd_ready, 32'd0);
    checkOutput({tag, "_rsp_valid"}, bus.o_rsp_valid, 32'd0);
    checkOutput({tag, "_rsp_err"}, bus.o_rsp_err, 32'd0);
    checkOutput({tag, "_rsp_data"}, bus.o_rsp_data, 32'd0);
    checkOutput({tag, "_rsp_op"}, bus.o_rsp_op, 32'd0);
    checkOutput({tag, "_q_wrt"}, q_wrt, 32'd0);
    checkOutput({tag, "_q_read"}, q_read, 32'd0);
    checkOutput({tag, "_q_data"}, q_data, 32'd0);
  endtask

  initial begin : watchdog
    #300000;
    miscompares++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : stimulus
    int n;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_op    = 2'd0;
    bus.i_cmd_data  = '0;
    bus.i_rsp_ready = 1'b0;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkResetZeros("por");
    syncEdge();
    RST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("ready_after_por", bus.o_cmd_ready, 32'd1);
    syncEdge();

    $display("[TB] dequeue on empty queue");
    applyStimulus(DEQUEUE, 16'($urandom));
    waitResponse();

    $display("[TB] enqueue 300, 700, 50 then replace and peek");
    applyStimulus(ENQUEUE, 16'd300); waitResponse();
    applyStimulus(ENQUEUE, 16'd700); waitResponse();
    applyStimulus(ENQUEUE, 16'd50);  waitResponse();
    applyStimulus(REPLACE, 16'd10);  waitResponse();
    applyStimulus(PEEK, 16'($urandom)); waitResponse();

    $display("[TB] reset in the middle of an enqueue");
    applyStimulus(ENQUEUE, 16'd100);
    syncEdge();
    RST = 1'b1;
    sb_q.delete();
    seen_strobes = 0;
    bench_ops = 0;
    bench_errs = 0;
    @(posedge CLK);
    @(negedge CLK);
    checkResetZeros("mid_wait_rst");
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("ready_after_rst", bus.o_cmd_ready, 32'd1);
`ifdef PQ_CMD_DRIVER_STATS_EN
    checkOutput("stat_ops_after_rst", stat_ops, 32'd0);
    checkOutput("stat_errs_after_rst", stat_errs, 32'd0);
`endif
    syncEdge();

    $display("[TB] fill to full, overflow, drain, underflow");
    while (ref_q.size() < DEPTH) begin
      applyStimulus(ENQUEUE, 16'($urandom_range(1, 60000)));
      waitResponse();
    end
    applyStimulus(ENQUEUE, 16'd5); waitResponse();
    repeat (DEPTH + 1) begin
      applyStimulus(DEQUEUE, 16'($urandom));
      waitResponse();
    end

    $display("[TB] response held while consumer stalls");
    applyStimulus(ENQUEUE, 16'($urandom));
    n = 0;
    @(negedge CLK);
    while (!bus.o_rsp_valid && n < 20) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("stall_rsp_valid_rise", bus.o_rsp_valid, 32'd1);
    repeat (10) begin
      @(negedge CLK);
      if (sb_q.size() != 0) begin
        checkOutput("stall_rsp_valid", bus.o_rsp_valid, 32'd1);
        checkOutput("stall_rsp_data", bus.o_rsp_data, sb_q[0].data);
        checkOutput("stall_rsp_err", bus.o_rsp_err, sb_q[0].err);
        checkOutput("stall_rsp_op", bus.o_rsp_op, sb_q[0].op);
      end else begin
        checkOutput("stall_pending_entry", 32'd0, 32'd1);
      end
      checkOutput("stall_cmd_ready", bus.o_cmd_ready, 32'd0);
      checkOutput("stall_q_wrt", q_wrt, 32'd0);
      checkOutput("stall_q_read", q_read, 32'd0);
    end
    waitResponse();

    $display("[TB] random command mix");
    repeat (80) begin
      applyStimulus(op_t'($urandom_range(0, 3)), 16'($urandom_range(0, 4000)));
      waitResponse();
    end

`ifdef PQ_CMD_DRIVER_STATS_EN
    checkOutput("stat_ops_final", stat_ops, bench_ops);
    checkOutput("stat_errs_final", stat_errs, bench_errs);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
